// File: rtl/tx_rd_req_engine.sv
// rtl/tx_rd_req_engine.sv - tag-managed multi-TLP PCIe MRd generator on the 64-bit TRN TX interface
module tx_rd_req_engine #(
    parameter int RD_REQ_DW = 128,
    parameter int TAG_W     = 5,
    parameter int MAX_BURST = 4
) (
    input  logic              trn_clk,
    input  logic              reset_n,
    output logic [63:0]       trn_td,
    output logic [7:0]        trn_trem_n,
    output logic              trn_tsof_n,
    output logic              trn_teof_n,
    output logic              trn_tsrc_rdy_n,
    input  logic              trn_tdst_rdy_n,
    input  logic [3:0]        trn_tbuf_av,
    input  logic [15:0]       cfg_completer_id,
    input  logic [63:0]       req_addr,
    input  logic [15:0]       req_num_tlps,
    input  logic              req_valid,
    output logic              req_ack,
    output logic              busy,
    input  logic              tag_rel_valid,
    input  logic [TAG_W-1:0]  tag_rel,
    output logic [TAG_W:0]    tags_in_use,
    input  logic              my_turn,
    output logic              driving_interface
);
    localparam int NTAGS = 1 << TAG_W;
    localparam int BW    = $clog2(MAX_BURST + 1);
    localparam logic [63:0]   ADDR_STEP   = 64'(RD_REQ_DW * 4);
    localparam logic [9:0]    LEN         = 10'(RD_REQ_DW);
    localparam logic [BW-1:0] MAX_BURST_C = BW'(MAX_BURST);

    typedef enum logic [1:0] {IDLE, BEAT0, BEAT1} state_t;

    state_t              state_q;
    logic [63:0]         addr_q;
    logic [15:0]         remaining_q;
    logic [TAG_W-1:0]    tag_ptr_q, tag_ptr_d;
    logic [NTAGS-1:0]    bitmap_q, bitmap_d;
    logic [TAG_W:0]      in_use_q, in_use_d;
    logic [BW-1:0]       burst_q, burst_d;
    logic [63:0]         td_q;
    logic [7:0]          trem_q;
    logic                sof_q, eof_q, src_rdy_q, ack_q, drv_q;

    logic                accept, alloc, rel_eff, launch_now, launch_next;
    logic [63:0]         addr_nxt;
    logic [15:0]         remaining_nxt;
    logic                unused_tbuf;

    assign unused_tbuf = ^trn_tbuf_av[3:1];

    function automatic logic [63:0] mrd_hdr(input logic [63:0] a, input logic [TAG_W-1:0] t,
                                            input logic [15:0] id);
        logic [6:0] ft;
        ft = (a[63:32] == 32'h0) ? 7'b000_0000 : 7'b010_0000;
        return {1'b0, ft, 1'b0, 3'b000, 4'b0000, 1'b0, 1'b0, 2'b10, 2'b00, LEN,
                id, 8'(t), 4'hF, 4'hF};
    endfunction

    // Returns {trem_n, td} for the address beat; 3DW headers leave the lower DW empty.
    function automatic logic [71:0] addr_beat(input logic [63:0] a);
        if (a[63:32] == 32'h0)
            return {8'h0F, a[31:0], 32'h0};
        return {8'h00, a};
    endfunction

    assign busy    = (remaining_q != 16'd0);
    assign accept  = !src_rdy_q && !trn_tdst_rdy_n;
    assign alloc   = (state_q == BEAT1) && accept;
    assign rel_eff = tag_rel_valid && bitmap_q[tag_rel];

    assign addr_nxt      = addr_q + ADDR_STEP;
    assign remaining_nxt = remaining_q - 16'd1;
    assign tag_ptr_d     = tag_ptr_q + TAG_W'(alloc);
    assign burst_d       = burst_q + BW'(1);
    assign in_use_d      = in_use_q + (TAG_W+1)'(alloc) - (TAG_W+1)'(rel_eff);

    always_comb begin
        bitmap_d = bitmap_q;
        if (rel_eff)
            bitmap_d[tag_rel] = 1'b0;
        if (alloc)
            bitmap_d[tag_ptr_q] = 1'b1;
    end

    assign launch_now  = busy && trn_tbuf_av[0] && !trn_tdst_rdy_n && my_turn
                         && !bitmap_q[tag_ptr_q];
    // Back-to-back decision must see the state as it will be after this accept.
    assign launch_next = (remaining_nxt != 16'd0) && trn_tbuf_av[0] && !trn_tdst_rdy_n
                         && my_turn && !bitmap_d[tag_ptr_d] && (burst_d < MAX_BURST_C);

    always_ff @(posedge trn_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            addr_q      <= 64'h0;
            remaining_q <= 16'h0;
            tag_ptr_q   <= '0;
            bitmap_q    <= '0;
            in_use_q    <= '0;
            burst_q     <= '0;
            td_q        <= 64'h0;
            trem_q      <= 8'hFF;
            sof_q       <= 1'b1;
            eof_q       <= 1'b1;
            src_rdy_q   <= 1'b1;
            ack_q       <= 1'b0;
            drv_q       <= 1'b0;
        end else begin
            ack_q     <= 1'b0;
            bitmap_q  <= bitmap_d;
            in_use_q  <= in_use_d;
            tag_ptr_q <= tag_ptr_d;
            case (state_q)
                IDLE: begin
                    if (req_valid && !busy) begin
                        addr_q      <= req_addr;
                        remaining_q <= req_num_tlps;
                        ack_q       <= 1'b1;
                    end else if (launch_now) begin
                        state_q   <= BEAT0;
                        drv_q     <= 1'b1;
                        burst_q   <= '0;
                        td_q      <= mrd_hdr(addr_q, tag_ptr_q, cfg_completer_id);
                        trem_q    <= 8'h00;
                        sof_q     <= 1'b0;
                        src_rdy_q <= 1'b0;
                    end
                end
                BEAT0: begin
                    if (accept) begin
                        state_q        <= BEAT1;
                        sof_q          <= 1'b1;
                        eof_q          <= 1'b0;
                        {trem_q, td_q} <= addr_beat(addr_q);
                    end
                end
                BEAT1: begin
                    if (accept) begin
                        addr_q      <= addr_nxt;
                        remaining_q <= remaining_nxt;
                        burst_q     <= burst_d;
                        if (launch_next) begin
                            state_q <= BEAT0;
                            td_q    <= mrd_hdr(addr_nxt, tag_ptr_d, cfg_completer_id);
                            trem_q  <= 8'h00;
                            sof_q   <= 1'b0;
                            eof_q   <= 1'b1;
                        end else begin
                            state_q   <= IDLE;
                            td_q      <= 64'h0;
                            trem_q    <= 8'hFF;
                            eof_q     <= 1'b1;
                            src_rdy_q <= 1'b1;
                            drv_q     <= 1'b0;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign trn_td            = td_q;
    assign trn_trem_n        = trem_q;
    assign trn_tsof_n        = sof_q;
    assign trn_teof_n        = eof_q;
    assign trn_tsrc_rdy_n    = src_rdy_q;
    assign req_ack           = ack_q;
    assign tags_in_use       = in_use_q;
    assign driving_interface = drv_q;
endmodule
